// File: rtl/show_cell_overlay.sv
// Cell-map overlay on an RGB565 stream: a GRID_X*GRID_Y class map is painted over a picture window.
// Pipeline: stage 0 position/cell tracking + map read, stage 1 registered context, stage 2 colour mix.
module show_cell_overlay #(
  parameter int P_W    = 12,
  parameter int IMG_X  = 640,
  parameter int IMG_Y  = 480,
  parameter int WIN_X1 = 64,
  parameter int WIN_Y1 = 48,
  parameter int CELL   = 8,
  parameter int GRID_X = 64,
  parameter int GRID_Y = 48,
  parameter int CLS_W  = 2,
  parameter int A_W    = 12
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        i_map_we,
  input  logic [A_W-1:0]              i_map_addr,
  input  logic [CLS_W-1:0]            i_map_din,
  input  logic [16*(2**CLS_W)-1:0]    i_palette,
  input  logic [1:0]                  i_mode,
  input  logic                        i_sof,
  input  logic                        i_valid,
  input  logic [15:0]                 i_data,
  output logic                        o_valid,
  output logic [15:0]                 o_data,
  output logic [15:0]                 o_data_raw,
  output logic                        o_inwin
);

  localparam int NPAL  = 2**CLS_W;
  localparam int CELLS = GRID_X * GRID_Y;
  localparam int LX_W  = $clog2(CELL);
  localparam int COL_W = (GRID_X > 1) ? $clog2(GRID_X) : 1;

  localparam logic [P_W-1:0]   X_LO   = P_W'(WIN_X1);
  localparam logic [P_W-1:0]   X_HI   = P_W'(WIN_X1 + GRID_X*CELL - 1);
  localparam logic [P_W-1:0]   Y_LO   = P_W'(WIN_Y1);
  localparam logic [P_W-1:0]   Y_HI   = P_W'(WIN_Y1 + GRID_Y*CELL - 1);
  localparam logic [P_W-1:0]   X_LAST = P_W'(IMG_X - 1);
  localparam logic [P_W-1:0]   Y_LAST = P_W'(IMG_Y - 1);
  localparam logic [LX_W-1:0]  L_LAST = LX_W'(CELL - 1);
  localparam logic [COL_W-1:0] C_LAST = COL_W'(GRID_X - 1);
  localparam logic [A_W:0]     A_LIM  = (A_W+1)'(CELLS);

  // ---------------- stage 0: frame position ----------------
  logic [P_W-1:0] cnt_x, cnt_y, cur_x, cur_y, nxt_x, nxt_y;
  logic           at_origin, inwin0, border0;

  always_comb begin
    cur_x = i_sof ? '0 : cnt_x;
    cur_y = i_sof ? '0 : cnt_y;
    if (cur_x == X_LAST) begin
      nxt_x = '0;
      nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + P_W'(1);
    end else begin
      nxt_x = cur_x + P_W'(1);
      nxt_y = cur_y;
    end
  end

  assign at_origin = i_valid && (cur_x == '0) && (cur_y == '0);
  assign inwin0    = i_valid && (cur_x >= X_LO) && (cur_x <= X_HI)
                             && (cur_y >= Y_LO) && (cur_y <= Y_HI);

  // ---------------- stage 0: incremental cell tracking ----------------
  logic [LX_W-1:0]  lx_q, ly_q, lx, ly, lx_n, ly_n;
  logic [COL_W-1:0] col_q, col, col_n;
  logic [A_W-1:0]   rb_q, rb, rb_n, rd_addr;
  logic             lx_end, ly_end, col_end, line_end;

  always_comb begin
    // the origin pixel sees cleared counters so a resync takes effect on itself
    lx  = at_origin ? '0 : lx_q;
    ly  = at_origin ? '0 : ly_q;
    col = at_origin ? '0 : col_q;
    rb  = at_origin ? '0 : rb_q;
    lx_end   = (lx == L_LAST);
    ly_end   = (ly == L_LAST);
    col_end  = (col == C_LAST);
    line_end = lx_end && col_end;
    lx_n  = lx_end ? '0 : lx + LX_W'(1);
    col_n = lx_end ? (col_end ? '0 : col + COL_W'(1)) : col;
    ly_n  = line_end ? (ly_end ? '0 : ly + LX_W'(1)) : ly;
    rb_n  = (line_end && ly_end) ? rb + A_W'(GRID_X) : rb;
  end

  assign rd_addr = rb + A_W'(col);
  assign border0 = (lx == '0) || (lx == L_LAST) || (ly == '0) || (ly == L_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_x <= '0;
      cnt_y <= '0;
      lx_q  <= '0;
      ly_q  <= '0;
      col_q <= '0;
      rb_q  <= '0;
    end else begin
      if (i_valid) begin
        cnt_x <= nxt_x;
        cnt_y <= nxt_y;
      end
      if (inwin0) begin
        lx_q  <= lx_n;
        ly_q  <= ly_n;
        col_q <= col_n;
        rb_q  <= rb_n;
      end else if (at_origin) begin
        lx_q  <= '0;
        ly_q  <= '0;
        col_q <= '0;
        rb_q  <= '0;
      end
    end
  end

  // ---------------- class map: read-first, 1-cycle read ----------------
  logic [CLS_W-1:0] map_mem [0:2**A_W-1];
  logic [CLS_W-1:0] cls1;

  always_ff @(posedge sys_clk) begin
    if (i_map_we && ({1'b0, i_map_addr} < A_LIM))
      map_mem[i_map_addr] <= i_map_din;
    cls1 <= map_mem[rd_addr];
  end

  // ---------------- stage 1 ----------------
  logic [2:1]  vld_pipe;
  logic [15:0] data1;
  logic        inwin1, border1;
  logic [1:0]  mode_act;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe[1] <= 1'b0;
      data1       <= '0;
      inwin1      <= 1'b0;
      border1     <= 1'b0;
      mode_act    <= '0;
    end else begin
      vld_pipe[1] <= i_valid;
      data1       <= i_data;
      inwin1      <= inwin0;
      border1     <= border0;
      // mode only changes on a frame origin so a frame is never torn
      if (at_origin) mode_act <= i_mode;
    end
  end

  // ---------------- stage 2: colour mix ----------------
  logic [NPAL-1:0][15:0] pal;
  logic [15:0]           pv, ovl, blend;
  logic [5:0]            sum_r, sum_b;
  logic [6:0]            sum_g;

  assign pal   = i_palette;
  assign pv    = pal[cls1];
  assign sum_r = {1'b0, data1[15:11]} + {1'b0, pv[15:11]};
  assign sum_g = {1'b0, data1[10:5]}  + {1'b0, pv[10:5]};
  assign sum_b = {1'b0, data1[4:0]}   + {1'b0, pv[4:0]};
  assign blend = {5'(sum_r >> 1), 6'(sum_g >> 1), 5'(sum_b >> 1)};

  always_comb begin
    ovl = data1;
    if (inwin1 && (cls1 != '0)) begin
      case (mode_act)
        2'd1:    ovl = pv;
        2'd2:    ovl = blend;
        2'd3:    if (border1) ovl = pv;
        default: ovl = data1;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe[2] <= 1'b0;
      o_data      <= '0;
      o_data_raw  <= '0;
      o_inwin     <= 1'b0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      o_data      <= ovl;
      o_data_raw  <= data1;
      o_inwin     <= inwin1;
    end
  end

  assign o_valid = vld_pipe[2];

endmodule

// File: tb/tb_show_cell_overlay.sv
// Bench for show_cell_overlay on a shrunken frame; a division-based model predicts every output pixel.
module tb_show_cell_overlay;
  localparam int P_W = 8, IMG_X = 32, IMG_Y = 24, WX = 4, WY = 3, CELL = 5;
  localparam int GX = 4, GY = 3, CLS_W = 2, A_W = 4, NC = GX*GY;
  localparam int LIM = IMG_X*IMG_Y + 4;

  logic           sys_clk, sys_rst_n;
  logic           i_map_we;
  logic [A_W-1:0] i_map_addr;
  logic [1:0]     i_map_din;
  logic [63:0]    i_palette;
  logic [1:0]     i_mode;
  logic           i_sof, i_valid;
  logic [15:0]    i_data;
  logic           o_valid, o_inwin;
  logic [15:0]    o_data, o_data_raw;

  show_cell_overlay #(
    .P_W(P_W), .IMG_X(IMG_X), .IMG_Y(IMG_Y), .WIN_X1(WX), .WIN_Y1(WY), .CELL(CELL),
    .GRID_X(GX), .GRID_Y(GY), .CLS_W(CLS_W), .A_W(A_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_map_we(i_map_we), .i_map_addr(i_map_addr),
    .i_map_din(i_map_din), .i_palette(i_palette), .i_mode(i_mode), .i_sof(i_sof),
    .i_valid(i_valid), .i_data(i_data), .o_valid(o_valid), .o_data(o_data),
    .o_data_raw(o_data_raw), .o_inwin(o_inwin)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct { logic v; logic [15:0] d; logic [15:0] raw; logic iw; } exp_t;
  typedef struct { logic [1:0] mode; int cls; logic [15:0] pv; logic [15:0] d; int ox; int oy; logic [15:0] exp; } vec_t;

  int checks = 0, errors = 0;
  int mx, my, hits, inw;
  logic [1:0] mmode;
  logic [1:0] mmap [NC];
  exp_t p1, p2;
  localparam exp_t ZERO = '{v: 1'b0, d: 16'h0, raw: 16'h0, iw: 1'b0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] blend(input logic [15:0] a, input logic [15:0] b);
    int r, g, bl;
    r  = (int'(a[15:11]) + int'(b[15:11])) / 2;
    g  = (int'(a[10:5])  + int'(b[10:5]))  / 2;
    bl = (int'(a[4:0])   + int'(b[4:0]))   / 2;
    return {5'(r), 6'(g), 5'(bl)};
  endfunction

  // Model one input cycle, clock it, then compare the pixel that entered two edges ago.
  task automatic step(input logic v, input logic s, input logic [15:0] d);
    exp_t e;
    int x, y, cls, lx, ly;
    logic [15:0] pv;
    logic bd;
    i_valid = v; i_sof = s; i_data = d;
    e = '{v: v, d: d, raw: d, iw: 1'b0};
    if (v) begin
      x = s ? 0 : mx;
      y = s ? 0 : my;
      if (x == 0 && y == 0) mmode = i_mode;
      if (x >= WX && x < WX + GX*CELL && y >= WY && y < WY + GY*CELL) begin
        e.iw = 1'b1;
        lx  = (x - WX) % CELL;
        ly  = (y - WY) % CELL;
        cls = mmap[((y - WY) / CELL) * GX + (x - WX) / CELL];
        pv  = i_palette[cls*16 +: 16];
        bd  = (lx == 0) || (lx == CELL-1) || (ly == 0) || (ly == CELL-1);
        if (cls != 0) begin
          if (mmode == 2'd1 || (mmode == 2'd3 && bd)) e.d = pv;
          else if (mmode == 2'd2) e.d = blend(d, pv);
        end
      end
      mx = x + 1; my = y;
      if (mx == IMG_X) begin
        mx = 0; my = y + 1;
        if (my == IMG_Y) my = 0;
      end
    end
    if (i_map_we && int'(i_map_addr) < NC) mmap[i_map_addr] = i_map_din;
    @(posedge sys_clk);
    p2 = p1; p1 = e;
    #1;
    i_map_we = 1'b0;
    chk("o_valid", o_valid, p2.v);
    chk("o_data_raw", o_data_raw, p2.raw);
    if (p2.v) begin
      chk("o_data", o_data, p2.d);
      chk("o_inwin", o_inwin, p2.iw);
    end
    if (o_valid && o_data == 16'hF800) hits++;
    if (o_valid && o_inwin) inw++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic wr(input int a, input int c);
    i_map_we = 1'b1; i_map_addr = A_W'(a); i_map_din = 2'(c);
    step(1'b0, 1'b0, 16'h0);
  endtask

  // stream valid pixels until the next pixel would sit at (tx,ty)
  task automatic run_to(input int tx, input int ty, input logic [15:0] d);
    int n = 0;
    while (!(mx == tx && my == ty) && n < LIM) begin
      step(1'b1, 1'b0, d);
      n++;
    end
    checks++;
    if (n >= LIM) begin
      errors++;
      $display("FAIL run_to_bound: got %0d cycles expected fewer than %0d", n, LIM);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_data = 16'h0; i_map_we = 1'b0;
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_data_raw", o_data_raw, 0);
    chk("rst_o_inwin", o_inwin, 0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mx = 0; my = 0; mmode = 2'd0; p1 = ZERO; p2 = ZERO;
  endtask

  vec_t vecs [11];

  initial begin
    vecs = '{
      '{2'd1, 1, 16'hF800, 16'h001F, 1, 1, 16'hF800},
      '{2'd2, 1, 16'h0000, 16'hFFFF, 2, 3, 16'h7BEF},
      '{2'd2, 2, 16'h5678, 16'h1234, 0, 0, 16'h3456},
      '{2'd0, 1, 16'hF800, 16'h1234, 1, 1, 16'h1234},
      '{2'd1, 0, 16'hF800, 16'hABCD, 1, 1, 16'hABCD},
      '{2'd3, 2, 16'h07E0, 16'h1111, 0, 2, 16'h07E0},
      '{2'd3, 2, 16'h07E0, 16'h1111, 2, 2, 16'h1111},
      '{2'd3, 3, 16'hF81F, 16'h2222, 4, 4, 16'hF81F},
      '{2'd2, 3, 16'hFFFF, 16'h0000, 3, 1, 16'h7BEF},
      '{2'd1, 3, 16'hBEEF, 16'h0F0F, 4, 0, 16'hBEEF},
      '{2'd3, 1, 16'hAAAA, 16'h5555, 3, 3, 16'h5555}
    };
    sys_rst_n = 1'b0; i_map_we = 1'b0; i_map_addr = '0; i_map_din = '0;
    i_palette = '0; i_mode = '0; i_sof = 1'b0; i_valid = 1'b0; i_data = '0;
    mx = 0; my = 0; mmode = 2'd0; p1 = ZERO; p2 = ZERO; hits = 0; inw = 0;
    repeat (2) @(posedge sys_clk);
    do_reset();

    // known map contents, plus out-of-range writes that must not land anywhere
    for (int a = 0; a < NC; a++) wr(a, int'($urandom_range(0, 3)));
    wr(12, 3);
    wr(15, 3);

    // table-driven single-pixel vectors, all aimed at cell 0
    foreach (vecs[k]) begin
      logic [63:0] pal;
      idle(3);
      pal = '0;
      pal[vecs[k].cls*16 +: 16] = vecs[k].pv;
      i_palette = pal;
      wr(0, vecs[k].cls);
      i_mode = vecs[k].mode;
      step(1'b1, 1'b1, vecs[k].d);
      run_to(WX + vecs[k].ox, WY + vecs[k].oy, vecs[k].d);
      step(1'b1, 1'b0, vecs[k].d);
      step(1'b0, 1'b0, 16'h0);
      chk($sformatf("vec%0d", k), o_data, vecs[k].exp);
    end

    // one lit cell in a full frame of replace mode
    idle(3);
    for (int a = 0; a < NC; a++) wr(a, (a == 0) ? 1 : 0);
    i_palette = {16'h0, 16'h0, 16'hF800, 16'h0};
    i_mode = 2'd1;
    hits = 0; inw = 0;
    step(1'b1, 1'b1, 16'h001F);
    for (int i = 1; i < IMG_X*IMG_Y; i++) step(1'b1, 1'b0, 16'h001F);
    idle(2);
    chk("replace_cell_count", hits, CELL*CELL);
    chk("inwin_count", inw, GX*CELL*GY*CELL);

    // mode changed 1->0 mid-frame: frame stays replaced, next frame bypassed
    idle(2);
    wr(8, 1);
    i_palette = {16'h0, 16'h0, 16'h07E0, 16'h0};
    i_mode = 2'd1;
    step(1'b1, 1'b1, 16'h4321);
    run_to(0, WY + 8, 16'h4321);
    i_mode = 2'd0;
    run_to(WX + 2, WY + 12, 16'h4321);
    step(1'b1, 1'b0, 16'h4321);
    step(1'b0, 1'b0, 16'h0);
    chk("mode_hold_frame", o_data, 16'h07E0);
    run_to(WX + 2, WY + 12, 16'h4321);
    step(1'b1, 1'b0, 16'h4321);
    step(1'b0, 1'b0, 16'h0);
    chk("mode_next_frame", o_data, 16'h4321);

    // write map[5] while its last pixel is being read: old class now, new class next frame
    idle(2);
    wr(5, 1);
    i_palette = {16'h0, 16'hF800, 16'h07E0, 16'h0};
    i_mode = 2'd1;
    step(1'b1, 1'b1, 16'hAAAA);
    run_to(WX + 9, WY + 9, 16'hAAAA);
    i_map_we = 1'b1; i_map_addr = 4'd5; i_map_din = 2'd2;
    step(1'b1, 1'b0, 16'hAAAA);
    step(1'b0, 1'b0, 16'h0);
    chk("read_first_old", o_data, 16'h07E0);
    run_to(WX + 9, WY + 9, 16'hAAAA);
    step(1'b1, 1'b0, 16'hAAAA);
    step(1'b0, 1'b0, 16'h0);
    chk("read_first_new", o_data, 16'hF800);

    // mid-frame sof moves the origin and the window with it
    wr(0, 3);
    i_palette = {16'h1234, 16'hF800, 16'h07E0, 16'h0};
    run_to(10, 2, 16'h5A5A);
    step(1'b1, 1'b1, 16'h5A5A);
    run_to(WX, WY, 16'h5A5A);
    step(1'b1, 1'b0, 16'h5A5A);
    step(1'b0, 1'b0, 16'h0);
    chk("sof_realign", o_data, 16'h1234);

    // reset in the middle of a line
    run_to(WX + 3, WY + 1, 16'h0F0F);
    step(1'b1, 1'b0, 16'h0F0F);
    do_reset();
    i_mode = 2'd2;
    for (int i = 0; i < 3*IMG_X; i++) step(1'b1, 1'b0, 16'hC3C3);

    // randomized traffic against the model
    idle(2);
    i_palette = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) i_mode = 2'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        i_map_we = 1'b1; i_map_addr = 4'($urandom); i_map_din = 2'($urandom);
      end
      step($urandom_range(0, 99) < 85, $urandom_range(0, 599) == 0, 16'($urandom));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
